fp_class_pipe: RTL and testbench
================================

Name: fp_class_pipe

Overview:
- Parametrised, pipelined successor of the half-precision classifier.
- Accepts an IEEE-754 binary value of any EXP_W/SIG_W format through a valid/ready handshake.
- Returns its sign, class flags, unbiased signed exponent and significand, with subnormals normalised to the implied-1 position.
- Sits in front of the FPU arithmetic units (mul/add) as their operand unpacker; 2-stage pipeline with full backpressure.

Parameters:
EXP_W, 5, exponent field width (5 = half, 8 = single, 11 = double)
SIG_W, 10, stored fraction width (10 = half, 23 = single, 52 = double)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_f holds a valid operand
in_ready  output  1  block accepts in_f this cycle
in_f  input  1+EXP_W+SIG_W  packed operand {sign, exponent, fraction}
out_valid  output  1  result outputs valid
out_ready  input  1  downstream accepts result this cycle
out_sign  output  1  sign bit of operand
out_exp  output  EXP_W+2  signed unbiased exponent
out_sig  output  SIG_W+1  significand incl. implied bit
out_flags  output  6  {isSnan, isQnan, isInfinity, isZero, isSubnormal, isNormal}

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset: out_valid=0; both stage-valid bits=0; out_sign, out_exp, out_sig, out_flags=0. in_ready=1 once rst_n is released.
- Reset asserted mid-operation discards all in-flight operands; no partial result appears after release.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Latency: exactly 2 cycles from input transfer to out_valid with no stall; throughput 1 result/cycle.
- Stage registers S1, S2 each have a valid bit v1, v2; out_valid = v2.
- S2 loads from S1 when v1 & (!v2 | out_ready).
- S1 loads from input when in_valid & in_ready.
- in_ready = !v1 | !v2 | out_ready (combinational, no bubble).
- Simultaneous drain and fill of either stage in the same cycle is legal and loses nothing.
- S2 holds all outputs stable while out_valid & !out_ready.
- Stage 1:
  - Register the sign, raw fields and class flags.
  - expOnes = &exp field; expZeroes = ~|exp field; sigZeroes = ~|fraction field.
  - Flags are exactly one-hot: isSnan = expOnes & !sigZeroes & !frac[MSB]; isQnan = expOnes & frac[MSB]; isInfinity = expOnes & sigZeroes; isZero = expZeroes & sigZeroes; isSubnormal = expZeroes & !sigZeroes; isNormal = otherwise.
  - Compute and register the leading-zero count lz (0..SIG_W-1) of the fraction, used only when isSubnormal.
- Stage 2:
  - BIAS = 2^(EXP_W-1)-1.
  - Normal: out_exp = exp - BIAS (sign-extended); out_sig = {1, frac}.
  - Subnormal: out_sig = {0, frac} << (lz+1), so MSB = 1; out_exp = (1-BIAS) - (lz+1).
  - Zero, infinity, NaN: out_exp = raw exponent zero-extended; out_sig = {0, frac} (raw pass-through).
- Width rule: EXP_W+2 signed bits always hold the minimum exponent 1-BIAS-SIG_W for the supported formats.
- No rounding and no exceptions raised; the NaN payload is preserved.
- The flags, sign, exponent and significand for one operand are presented in the same cycle.

Test Plan:
- Default params; in_f=16'h3C00, out_ready=1 -> 2 cycles later: out_exp=0, out_sig=11'h400, flags=000001, sign=0.
- in_f=16'h0001 -> out_exp=-24, out_sig=11'h400, isSubnormal. in_f=16'h0200 -> out_exp=-15, out_sig=11'h400.
- Specials: 16'h7E00 -> isQnan, exp=31, sig=11'h200. 16'h7C01 -> isSnan, sig=11'h001. 16'hFC00 -> isInfinity, sign=1. 16'h8000 -> isZero, sign=1.
- Backpressure: stream 5 back-to-back operands with out_ready low for cycles 3-6 -> in_ready falls only once both stages are full; all 5 results emerge in order with no loss or duplication; outputs stay stable while stalled.
- Reset: assert rst_n=0 with v1=v2=1 -> out_valid=0 immediately (async); after release, no stale output and in_ready=1.
- EXP_W=8, SIG_W=23: 32'h00000001 -> out_exp=-149, out_sig=24'h800000. 32'h3F800000 -> out_exp=0, out_sig=24'h800000, isNormal.

Source files
------------

// File: rtl/fp_class_pipe_if.sv
// Operand/result handshake bundle for the pipelined IEEE-754 operand classifier.
// Carries a valid/ready input channel and a valid/ready result channel.
interface fp_class_pipe_if #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned SIG_W = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+SIG_W:0]   in_f;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_sign;
    logic [EXP_W+1:0]       out_exp;
    logic [SIG_W:0]         out_sig;
    logic [5:0]             out_flags;

    modport master (
        output in_valid, in_f, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig, out_flags
    );

    modport slave (
        input  in_valid, in_f, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig, out_flags
    );
endinterface

// File: rtl/fp_class_pipe.sv
// Two-stage IEEE-754 operand unpacker: classifies the operand, then emits sign, flags,
// unbiased exponent and significand with subnormals normalised to the implied-1 position.
module fp_class_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned SIG_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_class_pipe_if.slave bus
);
    localparam int unsigned OUT_EXP_W = EXP_W + 2;
    localparam int unsigned OUT_SIG_W = SIG_W + 1;
    localparam int unsigned LZ_W      = $clog2(SIG_W + 1);
    localparam int          BIAS      = (1 << (EXP_W - 1)) - 1;

    localparam logic [5:0] FL_SNAN   = 6'b100000;
    localparam logic [5:0] FL_QNAN   = 6'b010000;
    localparam logic [5:0] FL_INF    = 6'b001000;
    localparam logic [5:0] FL_ZERO   = 6'b000100;
    localparam logic [5:0] FL_SUB    = 6'b000010;
    localparam logic [5:0] FL_NORMAL = 6'b000001;

    logic                  v1;
    logic                  v2;
    logic                  s1Sign;
    logic [EXP_W-1:0]      s1Exp;
    logic [SIG_W-1:0]      s1Frac;
    logic [5:0]            s1Flags;
    logic [LZ_W-1:0]       s1Lz;

    logic                  outSign;
    logic [OUT_EXP_W-1:0]  outExp;
    logic [OUT_SIG_W-1:0]  outSig;
    logic [5:0]            outFlags;

    logic                  inFire;
    logic                  s2Load;
    logic [EXP_W-1:0]      inExp;
    logic [SIG_W-1:0]      inFrac;
    logic                  expOnes;
    logic                  expZeroes;
    logic                  sigZeroes;
    logic [5:0]            flagsC;
    logic [LZ_W-1:0]       lzC;
    logic [SIG_W-1:0]      lzScan;
    logic                  lzFound;
    logic [OUT_EXP_W-1:0]  expC;
    logic [OUT_SIG_W-1:0]  sigC;
    int                    expInt;

    // Handshake: a stage may fill in the same cycle it drains, so no bubble is inserted.
    assign inFire        = bus.in_valid && bus.in_ready;
    assign s2Load        = v1 && (!v2 || bus.out_ready);
    assign bus.in_ready  = !v1 || !v2 || bus.out_ready;
    assign bus.out_valid = v2;
    assign bus.out_sign  = outSign;
    assign bus.out_exp   = outExp;
    assign bus.out_sig   = outSig;
    assign bus.out_flags = outFlags;

    // Stage 1 classification; flags come out one-hot by construction.
    always_comb begin
        inExp     = bus.in_f[SIG_W +: EXP_W];
        inFrac    = bus.in_f[SIG_W-1:0];
        expOnes   = &inExp;
        expZeroes = ~|inExp;
        sigZeroes = ~|inFrac;
        flagsC    = FL_NORMAL;
        if (expOnes) begin
            if (sigZeroes) begin
                flagsC = FL_INF;
            end else if (inFrac[SIG_W-1]) begin
                flagsC = FL_QNAN;
            end else begin
                flagsC = FL_SNAN;
            end
        end else if (expZeroes) begin
            flagsC = sigZeroes ? FL_ZERO : FL_SUB;
        end
    end

    // Leading-zero count of the fraction; only meaningful for a non-zero fraction.
    always_comb begin
        lzC     = '0;
        lzScan  = inFrac;
        lzFound = 1'b0;
        for (int i = 0; i < int'(SIG_W); i++) begin
            if (!lzFound) begin
                if (lzScan[SIG_W-1]) begin
                    lzFound = 1'b1;
                end else begin
                    lzC    = lzC + 1'b1;
                    lzScan = lzScan << 1;
                end
            end
        end
    end

    // Stage 2 unpack: normals get the hidden bit, subnormals are shifted up, specials pass raw.
    always_comb begin
        expInt = 0;
        expC   = OUT_EXP_W'(s1Exp);
        sigC   = {1'b0, s1Frac};
        if (s1Flags == FL_NORMAL) begin
            expInt = int'(s1Exp) - BIAS;
            expC   = OUT_EXP_W'(expInt);
            sigC   = {1'b1, s1Frac};
        end else if (s1Flags == FL_SUB) begin
            expInt = 1 - BIAS - (int'(s1Lz) + 1);
            expC   = OUT_EXP_W'(expInt);
            sigC   = {1'b0, s1Frac} << (int'(s1Lz) + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            s1Sign   <= 1'b0;
            s1Exp    <= '0;
            s1Frac   <= '0;
            s1Flags  <= '0;
            s1Lz     <= '0;
            outSign  <= 1'b0;
            outExp   <= '0;
            outSig   <= '0;
            outFlags <= '0;
        end else begin
            v1 <= inFire || (v1 && !s2Load);
            v2 <= s2Load || (v2 && !bus.out_ready);
            if (inFire) begin
                s1Sign  <= bus.in_f[EXP_W+SIG_W];
                s1Exp   <= inExp;
                s1Frac  <= inFrac;
                s1Flags <= flagsC;
                s1Lz    <= lzC;
            end
            // Output registers only move on a stage-2 load, so a stall holds them steady.
            if (s2Load) begin
                outSign  <= s1Sign;
                outExp   <= expC;
                outSig   <= sigC;
                outFlags <= s1Flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_class_pipe.sv
// Bench for fp_class_pipe: directed half/single vectors, backpressure, reset and a random
// stream scored against a value-level model of the unpacking rules.
module tb_fp_class_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nTests = 0;
    int   nFail = 0;

    always #5 clk = ~clk;

    fp_class_pipe_if #(.EXP_W(5), .SIG_W(10)) busH ();
    fp_class_pipe_if #(.EXP_W(8), .SIG_W(23)) busS ();

    fp_class_pipe #(.EXP_W(5), .SIG_W(10)) dutH (.clk(clk), .rst_n(rst_n), .bus(busH.slave));
    fp_class_pipe #(.EXP_W(8), .SIG_W(23)) dutS (.clk(clk), .rst_n(rst_n), .bus(busS.slave));

    typedef struct {
        logic              s;
        int                e;
        longint unsigned   g;
        logic [5:0]        f;
    } res_t;

    res_t q[$];

    localparam int NDIR = 11;
    localparam logic [15:0] D_IN  [NDIR] = '{16'h3C00, 16'h0001, 16'h0200, 16'h7E00, 16'h7C01,
                                            16'hFC00, 16'h8000, 16'h7BFF, 16'h0400, 16'h83FF, 16'h7FFF};
    localparam logic        D_SGN [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam int          D_EXP [NDIR] = '{0, -24, -15, 31, 31, 31, 0, 15, -14, -15, 31};
    localparam logic [10:0] D_SIG [NDIR] = '{11'h400, 11'h400, 11'h400, 11'h200, 11'h001,
                                            11'h000, 11'h000, 11'h7FF, 11'h400, 11'h7FE, 11'h3FF};
    localparam logic [5:0]  D_FL  [NDIR] = '{6'b000001, 6'b000010, 6'b000010, 6'b010000, 6'b100000,
                                            6'b001000, 6'b000100, 6'b000001, 6'b000001, 6'b000010, 6'b010000};

    // Value-level reference: decode the fields and normalise subnormals by repeated doubling.
    function automatic res_t refModel(input int ew, input int sw, input longint unsigned bits);
        res_t r;
        longint unsigned e;
        longint unsigned f;
        int bias;
        f    = bits & ((64'd1 << sw) - 64'd1);
        e    = (bits >> sw) & ((64'd1 << ew) - 64'd1);
        r.s  = ((bits >> (ew + sw)) & 64'd1) != 64'd0;
        bias = (1 << (ew - 1)) - 1;
        if (e == (64'd1 << ew) - 64'd1) begin
            r.e = int'(e);
            r.g = f;
            if (f == 0) r.f = 6'b001000;
            else if (f >= (64'd1 << (sw - 1))) r.f = 6'b010000;
            else r.f = 6'b100000;
        end else if (e == 0) begin
            if (f == 0) begin
                r.e = 0; r.g = 0; r.f = 6'b000100;
            end else begin
                r.f = 6'b000010;
                r.g = f;
                r.e = 1 - bias;
                while (r.g < (64'd1 << sw)) begin
                    r.g = r.g * 2;
                    r.e = r.e - 1;
                end
            end
        end else begin
            r.f = 6'b000001;
            r.e = int'(e) - bias;
            r.g = f + (64'd1 << sw);
        end
        return r;
    endfunction

    function automatic logic [15:0] genHalf();
        int k = $urandom_range(0, 5);
        logic [4:0] e;
        logic [9:0] f;
        f = 10'($urandom);
        if ($urandom_range(0, 3) == 0) f = '0;
        case (k)
            0:       e = 5'h00;
            1:       e = 5'h1F;
            default: e = 5'($urandom_range(1, 30));
        endcase
        return {1'($urandom), e, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        nTests++;
        if (busH.out_valid !== 1'b0 || busH.in_ready !== 1'b1) begin
            nFail++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, want 0/1", busH.out_valid, busH.in_ready);
        end
        nTests++;
        if (busH.out_sign !== 1'b0 || busH.out_exp !== '0 || busH.out_sig !== '0 || busH.out_flags !== '0) begin
            nFail++;
            $display("FAIL reset_outputs: sign=%b exp=%h sig=%h flags=%b, want all 0",
                     busH.out_sign, busH.out_exp, busH.out_sig, busH.out_flags);
        end
        nTests++;
        if (busS.out_valid !== 1'b0 || busS.in_ready !== 1'b1 || busS.out_sig !== '0) begin
            nFail++;
            $display("FAIL reset_single: out_valid=%b in_ready=%b sig=%h, want 0/1/0",
                     busS.out_valid, busS.in_ready, busS.out_sig);
        end
    endtask

    task automatic test_half_directed();
        busH.out_ready = 1'b1;
        for (int i = 0; i < NDIR; i++) begin
            busH.in_valid = 1'b1;
            busH.in_f     = D_IN[i];
            tick();
            busH.in_valid = 1'b0;
            nTests++;
            if (busH.out_valid !== 1'b0) begin
                nFail++;
                $display("FAIL half_latency1 %h: out_valid=%b want 0", D_IN[i], busH.out_valid);
            end
            tick();
            nTests++;
            if (busH.out_valid !== 1'b1 || busH.out_sign !== D_SGN[i] ||
                int'($signed(busH.out_exp)) !== D_EXP[i] || busH.out_sig !== D_SIG[i] ||
                busH.out_flags !== D_FL[i]) begin
                nFail++;
                $display("FAIL half_vec %h: v=%b s=%b exp=%0d sig=%h fl=%b, want v=1 s=%b exp=%0d sig=%h fl=%b",
                         D_IN[i], busH.out_valid, busH.out_sign, $signed(busH.out_exp), busH.out_sig,
                         busH.out_flags, D_SGN[i], D_EXP[i], D_SIG[i], D_FL[i]);
            end
            tick();
            nTests++;
            if (busH.out_valid !== 1'b0) begin
                nFail++;
                $display("FAIL half_drain %h: out_valid=%b want 0", D_IN[i], busH.out_valid);
            end
        end
    endtask

    task automatic test_single_directed();
        logic [31:0] vin [2] = '{32'h00000001, 32'h3F800000};
        int          vexp [2] = '{-149, 0};
        logic [5:0]  vfl [2] = '{6'b000010, 6'b000001};
        busS.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            busS.in_valid = 1'b1;
            busS.in_f     = vin[i];
            tick();
            busS.in_valid = 1'b0;
            tick();
            nTests++;
            if (busS.out_valid !== 1'b1 || busS.out_sign !== 1'b0 || int'($signed(busS.out_exp)) !== vexp[i] ||
                busS.out_sig !== 24'h800000 || busS.out_flags !== vfl[i]) begin
                nFail++;
                $display("FAIL single_vec %h: v=%b s=%b exp=%0d sig=%h fl=%b, want v=1 s=0 exp=%0d sig=800000 fl=%b",
                         vin[i], busS.out_valid, busS.out_sign, $signed(busS.out_exp), busS.out_sig,
                         busS.out_flags, vexp[i], vfl[i]);
            end
        end
    endtask

    // Five back-to-back operands with the sink stalled for cycles 3..6.
    task automatic test_back_to_back();
        logic [15:0] ops [5];
        int sent = 0, done = 0, occ = 0, cyc = 0;
        bit sawFull = 1'b0;
        bit expReady;
        res_t r;
        for (int i = 0; i < 5; i++) ops[i] = genHalf();
        q.delete();
        while (done < 5 && cyc < 40) begin
            cyc++;
            busH.in_valid  = (sent < 5);
            busH.in_f      = ops[sent < 5 ? sent : 4];
            busH.out_ready = !(cyc >= 3 && cyc <= 6);
            #1;
            expReady = !(occ == 2 && !busH.out_ready);
            if (!expReady) sawFull = 1'b1;
            nTests++;
            if (busH.in_ready !== expReady) begin
                nFail++;
                $display("FAIL b2b_in_ready cyc%0d: got %b want %b", cyc, busH.in_ready, expReady);
            end
            if (busH.out_valid === 1'b1) begin
                nTests++;
                if (q.size() == 0) begin
                    nFail++;
                    $display("FAIL b2b_spurious cyc%0d: out_valid=1 with nothing outstanding", cyc);
                end else begin
                    r = q[0];
                    if (busH.out_sign !== r.s || int'($signed(busH.out_exp)) !== r.e ||
                        64'(busH.out_sig) !== r.g || busH.out_flags !== r.f) begin
                        nFail++;
                        $display("FAIL b2b_result cyc%0d: s=%b exp=%0d sig=%h fl=%b, want s=%b exp=%0d sig=%h fl=%b",
                                 cyc, busH.out_sign, $signed(busH.out_exp), busH.out_sig, busH.out_flags,
                                 r.s, r.e, r.g, r.f);
                    end
                    if (busH.out_ready) begin
                        void'(q.pop_front());
                        occ--;
                        done++;
                    end
                end
            end
            if (busH.in_valid && busH.in_ready) begin
                q.push_back(refModel(5, 10, 64'(busH.in_f)));
                sent++;
                occ++;
            end
            @(posedge clk);
            #1;
        end
        busH.in_valid  = 1'b0;
        busH.out_ready = 1'b1;
        nTests++;
        if (done != 5 || q.size() != 0) begin
            nFail++;
            $display("FAIL b2b_count: emitted %0d left %0d, want 5 and 0", done, q.size());
        end
        nTests++;
        if (!sawFull) begin
            nFail++;
            $display("FAIL b2b_full: pipeline never reached full with stalled sink, want full");
        end
    endtask

    task automatic test_reset_midflight();
        busH.out_ready = 1'b0;
        busH.in_valid  = 1'b1;
        busH.in_f      = genHalf();
        tick();
        busH.in_f = genHalf();
        tick();
        busH.in_valid = 1'b0;
        nTests++;
        if (busH.out_valid !== 1'b1 || busH.in_ready !== 1'b0) begin
            nFail++;
            $display("FAIL midrst_full: out_valid=%b in_ready=%b, want 1/0", busH.out_valid, busH.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nTests++;
        if (busH.out_valid !== 1'b0 || busH.out_flags !== '0 || busH.out_sig !== '0) begin
            nFail++;
            $display("FAIL midrst_async: out_valid=%b flags=%b sig=%h, want 0", busH.out_valid,
                     busH.out_flags, busH.out_sig);
        end
        tick();
        #2;
        rst_n = 1'b1;
        busH.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nTests++;
            if (busH.out_valid !== 1'b0 || busH.in_ready !== 1'b1) begin
                nFail++;
                $display("FAIL midrst_after%0d: out_valid=%b in_ready=%b, want 0/1", i,
                         busH.out_valid, busH.in_ready);
            end
        end
    endtask

    // Random valid/ready traffic followed by a bounded drain.
    task automatic test_random();
        int occ = 0, cyc = 0;
        bit expReady;
        res_t r;
        q.delete();
        while (cyc < 400 || (q.size() != 0 && cyc < 440)) begin
            if (cyc < 400) begin
                busH.in_valid  = ($urandom_range(0, 9) < 7);
                busH.out_ready = ($urandom_range(0, 9) < 6);
                busH.in_f      = genHalf();
            end else begin
                busH.in_valid  = 1'b0;
                busH.out_ready = 1'b1;
            end
            cyc++;
            #1;
            expReady = !(occ == 2 && !busH.out_ready);
            nTests++;
            if (busH.in_ready !== expReady) begin
                nFail++;
                $display("FAIL rand_in_ready cyc%0d: got %b want %b", cyc, busH.in_ready, expReady);
            end
            if (busH.out_valid === 1'b1) begin
                nTests++;
                if (q.size() == 0) begin
                    nFail++;
                    $display("FAIL rand_spurious cyc%0d: out_valid=1 with nothing outstanding", cyc);
                end else begin
                    r = q[0];
                    if (busH.out_sign !== r.s || int'($signed(busH.out_exp)) !== r.e ||
                        64'(busH.out_sig) !== r.g || busH.out_flags !== r.f) begin
                        nFail++;
                        $display("FAIL rand_result cyc%0d: s=%b exp=%0d sig=%h fl=%b, want s=%b exp=%0d sig=%h fl=%b",
                                 cyc, busH.out_sign, $signed(busH.out_exp), busH.out_sig, busH.out_flags,
                                 r.s, r.e, r.g, r.f);
                    end
                    if (busH.out_ready) begin
                        void'(q.pop_front());
                        occ--;
                    end
                end
            end
            if (busH.in_valid && busH.in_ready) begin
                q.push_back(refModel(5, 10, 64'(busH.in_f)));
                occ++;
            end
            @(posedge clk);
            #1;
        end
        nTests++;
        if (q.size() != 0) begin
            nFail++;
            $display("FAIL rand_drain: %0d results never emerged, want 0", q.size());
        end
        busH.in_valid = 1'b0;
    endtask

    initial begin
        busH.in_valid  = 1'b0;
        busH.in_f      = '0;
        busH.out_ready = 1'b1;
        busS.in_valid  = 1'b0;
        busS.in_f      = '0;
        busS.out_ready = 1'b1;
        #22;
        rst_n = 1'b1;
        test_reset();
        test_half_directed();
        test_single_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
